// File: rtl/sobel_frame_writer_if.sv
// Stream/frame-buffer bundle between the Sobel top, the frame writer and the output RAM.
// The master drives the gradient stream, and the slave (the frame writer) drives the write port and status.
interface sobel_frame_writer_if #(
   parameter int ADDR_W = 12
);
   logic              Start;
   logic              Dop;
   logic [7:0]        Gradient;
   logic              Finish;
   logic              WrEn;
   logic [ADDR_W-1:0] WrAddr;
   logic [7:0]        WrData;
   logic [7:0]        Row;
   logic [7:0]        Column;
   logic [ADDR_W:0]   EdgeCount;
   logic              Busy;
   logic              Done;
   logic              Underrun;
   logic              Overrun;

   modport master (
      output Start, Dop, Gradient, Finish,
      input  WrEn, WrAddr, WrData, Row, Column, EdgeCount,
             Busy, Done, Underrun, Overrun
   );

   modport slave (
      input  Start, Dop, Gradient, Finish,
      output WrEn, WrAddr, WrData, Row, Column, EdgeCount,
             Busy, Done, Underrun, Overrun
   );
endinterface

// File: rtl/sobel_frame_writer.sv
// Collects the Sobel gradient stream into a raster-order frame buffer, tracking position,
// the edge-pixel count and short/long frame flags.
module sobel_frame_writer #(
   parameter int WIDTH  = 64,
   parameter int HEIGHT = 64,
   parameter int ADDR_W = 12
) (
   input  logic                  CLK,
   input  logic                  Reset,
   sobel_frame_writer_if.slave   bus
);

   localparam logic [ADDR_W:0] TOTAL    = (ADDR_W+1)'(WIDTH * HEIGHT);
   localparam logic [ADDR_W:0] LAST_COL = (ADDR_W+1)'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t            state_q;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W:0]   col_q, row_q, edge_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              busy_q, done_q, under_q, over_q;
   logic              accept, drop;

   // A pixel is either accepted or dropped as overrun; the count never wraps.
   always_comb begin
      accept = 1'b0;
      drop   = 1'b0;
      if (state_q == CAPTURE && bus.Dop) begin
         if (cnt_q < TOTAL) accept = 1'b1;
         else               drop   = 1'b1;
      end
      cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         col_q     <= '0;
         row_q     <= '0;
         edge_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         under_q   <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (bus.Start) begin
                  state_q <= CAPTURE;
                  cnt_q   <= '0;
                  col_q   <= '0;
                  row_q   <= '0;
                  edge_q  <= '0;
                  under_q <= 1'b0;
                  over_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            CAPTURE: begin
               if (accept) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= cnt_q[ADDR_W-1:0];
                  wr_data_q <= bus.Gradient;
                  cnt_q     <= cnt_d;
                  if (bus.Gradient != 8'd0) edge_q <= edge_q + 1'b1;
                  if (col_q == LAST_COL) begin
                     col_q <= '0;
                     row_q <= row_q + 1'b1;
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
               if (drop) over_q <= 1'b1;
               // Underrun judged on the count including a pixel accepted this same cycle.
               if (bus.Finish) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  if (cnt_d < TOTAL) under_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.WrEn      = wr_en_q;
   assign bus.WrAddr    = wr_addr_q;
   assign bus.WrData    = wr_data_q;
   assign bus.Row       = 8'(row_q);
   assign bus.Column    = 8'(col_q);
   assign bus.EdgeCount = edge_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.Underrun  = under_q;
   assign bus.Overrun   = over_q;

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Directed bench for sobel_frame_writer at WIDTH=4, HEIGHT=3, ADDR_W=4.
module tb_sobel_frame_writer;

   logic CLK = 1'b0;
   logic Reset;
   int   checks = 0;
   int   failures = 0;

   sobel_frame_writer_if #(.ADDR_W(4)) bus ();

   sobel_frame_writer #(.WIDTH(4), .HEIGHT(3), .ADDR_W(4)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   logic [3:0] wa[$];
   logic [7:0] wd[$];

   always @(negedge CLK) begin
      if (bus.WrEn === 1'b1) begin
         wa.push_back(bus.WrAddr);
         wd.push_back(bus.WrData);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_pix(input logic [7:0] g, input logic fin);
      bus.Dop = 1'b1;
      bus.Gradient = g;
      bus.Finish = fin;
      tick();
      bus.Dop = 1'b0;
      bus.Finish = 1'b0;
   endtask

   task automatic start_frame();
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
   endtask

   task automatic finish_frame();
      bus.Finish = 1'b1;
      tick();
      bus.Finish = 1'b0;
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
   endtask

   function automatic logic [31:0] all_outputs();
      return {bus.WrEn, bus.WrAddr, bus.WrData, bus.Row, bus.Column, bus.EdgeCount,
              bus.Busy, bus.Done, bus.Underrun, bus.Overrun};
   endfunction

   task automatic check_writes(input string tag, input int n, input int data_base);
      check({tag, "_count"}, 32'(wa.size()), n);
      for (int i = 0; i < n && i < wa.size(); i++) begin
         check({tag, "_addr"}, 32'(wa[i]), i);
         check({tag, "_data"}, 32'(wd[i]), data_base + i);
      end
   endtask

   initial begin
      bus.Start = 1'b0;
      bus.Dop = 1'b0;
      bus.Gradient = 8'd0;
      bus.Finish = 1'b0;
      Reset = 1'b0;
      repeat (3) tick();
      check("reset_outputs", all_outputs(), 0);
      Reset = 1'b1;
      tick();
      check("post_reset_outputs", all_outputs(), 0);

      // Normal frame
      clear_log();
      start_frame();
      check("start_busy", 32'(bus.Busy), 1);
      check("start_done", 32'(bus.Done), 0);
      send_pix(8'd0, 1'b0);
      check("lat_wren", 32'(bus.WrEn), 1);
      check("lat_addr", 32'(bus.WrAddr), 0);
      check("col_after1", 32'(bus.Column), 1);
      for (int i = 1; i < 12; i++) send_pix(8'(i), 1'b0);
      finish_frame();
      check("norm_done", 32'(bus.Done), 1);
      check("norm_busy", 32'(bus.Busy), 0);
      check("norm_edge", 32'(bus.EdgeCount), 11);
      check("norm_row", 32'(bus.Row), 3);
      check("norm_col", 32'(bus.Column), 0);
      check("norm_under", 32'(bus.Underrun), 0);
      check("norm_over", 32'(bus.Overrun), 0);
      check("norm_wren_off", 32'(bus.WrEn), 0);
      check("norm_addr_hold", 32'(bus.WrAddr), 11);
      check_writes("norm", 12, 0);

      // Gapped, last pixel together with Finish
      clear_log();
      start_frame();
      for (int i = 0; i < 12; i++) begin
         send_pix(8'(20 + i), (i == 11));
         if (i < 11) begin
            check("gap_wren_idle", 32'(bus.WrEn), 1);
            tick();
            check("gap_wren_low", 32'(bus.WrEn), 0);
         end
      end
      check("gap_done", 32'(bus.Done), 1);
      check("gap_under", 32'(bus.Underrun), 0);
      check("gap_edge", 32'(bus.EdgeCount), 12);
      tick();
      check_writes("gap", 12, 20);

      // Short frame
      clear_log();
      start_frame();
      check("short_edge_clr", 32'(bus.EdgeCount), 0);
      for (int i = 0; i < 7; i++) send_pix(8'(40 + i), 1'b0);
      finish_frame();
      check("short_under", 32'(bus.Underrun), 1);
      check("short_over", 32'(bus.Overrun), 0);
      check("short_row", 32'(bus.Row), 1);
      check("short_col", 32'(bus.Column), 3);
      check("short_edge", 32'(bus.EdgeCount), 7);
      check_writes("short", 7, 40);

      // Long frame
      clear_log();
      start_frame();
      check("long_under_clr", 32'(bus.Underrun), 0);
      for (int i = 0; i < 14; i++) send_pix(8'(60 + i), 1'b0);
      check("long_over", 32'(bus.Overrun), 1);
      finish_frame();
      check("long_under", 32'(bus.Underrun), 0);
      check("long_edge", 32'(bus.EdgeCount), 12);
      check("long_done", 32'(bus.Done), 1);
      check_writes("long", 12, 60);
      // Done ignores further pixels
      clear_log();
      send_pix(8'hff, 1'b0);
      tick();
      check("done_ignore_writes", 32'(wa.size()), 0);
      check("done_ignore_edge", 32'(bus.EdgeCount), 12);

      // Restart from DONE clears flags, then reset mid-frame
      start_frame();
      check("restart_over_clr", 32'(bus.Overrun), 0);
      check("restart_edge_clr", 32'(bus.EdgeCount), 0);
      check("restart_busy", 32'(bus.Busy), 1);
      clear_log();
      for (int i = 0; i < 5; i++) send_pix(8'(i + 1), 1'b0);
      bus.Dop = 1'b1;
      bus.Gradient = 8'h33;
      Reset = 1'b0;
      tick();
      bus.Dop = 1'b0;
      check("midreset_outputs", all_outputs(), 0);
      check("midreset_writes", 32'(wa.size()), 5);
      Reset = 1'b1;
      tick();
      clear_log();
      start_frame();
      for (int i = 0; i < 12; i++) send_pix(((i == 3) || (i == 7)) ? 8'd5 : 8'd0, 1'b0);
      finish_frame();
      check("rst_frame_edge", 32'(bus.EdgeCount), 2);
      check("rst_frame_done", 32'(bus.Done), 1);
      check("rst_first_addr", (wa.size() > 0) ? 32'(wa[0]) : 32'hffff_ffff, 0);
      check("rst_write_count", 32'(wa.size()), 12);
      start_frame();
      check("second_start_edge", 32'(bus.EdgeCount), 0);
      check("second_start_flags", {30'd0, bus.Underrun, bus.Overrun}, 0);
      check("second_start_busy", 32'(bus.Busy), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sobel_frame_writer.md
# sobel_frame_writer

Output-side collector for the Sobel pipeline. It consumes the `Dop`/`Gradient`/`Finish` stream produced by the Sobel top and writes each gradient pixel, in raster order, into an external single-port frame buffer. It also keeps row/column position and an edge-pixel count, and flags frames that end short or run long. It sits between the Sobel top and the output frame RAM, and is started by the same `Start` pulse that launches the Sobel run.

## Interface
Parameters:
- `WIDTH`, 64, output image columns (≥2).
- `HEIGHT`, 64, output image rows (≥2).
- `ADDR_W`, 12, frame-buffer address width; WIDTH*HEIGHT ≤ 2^ADDR_W.

Ports:
- `CLK`  in  1  single clock, all logic on rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `Start`  in  1  begin a new frame capture; sampled in IDLE and DONE only.
- `Dop`  in  1  gradient-valid strobe from the Sobel top; one pixel per high cycle.
- `Gradient`  in  8  gradient pixel, valid when `Dop`=1.
- `Finish`  in  1  end-of-frame pulse from the Sobel controller.
- `WrEn`  out  1  frame-buffer write enable.
- `WrAddr`  out  ADDR_W  frame-buffer write address.
- `WrData`  out  8  frame-buffer write data.
- `Row`  out  8  row of the next pixel to be accepted.
- `Column`  out  8  column of the next pixel to be accepted.
- `EdgeCount`  out  ADDR_W+1  accepted pixels with `Gradient` ≠ 0.
- `Busy`  out  1  high in CAPTURE.
- `Done`  out  1  high in DONE.
- `Underrun`  out  1  sticky: `Finish` arrived before WIDTH*HEIGHT pixels were accepted.
- `Overrun`  out  1  sticky: `Dop` arrived after WIDTH*HEIGHT pixels were accepted.

## Operation
- Three states: IDLE, CAPTURE, DONE. Reset forces IDLE.
- Every output is 0 while `Reset`=0 and in the first cycle after reset.
- IDLE -> CAPTURE on `Start`=1. Entering CAPTURE clears the pixel counter, `Row`, `Column`, `EdgeCount`, `Underrun` and `Overrun`.
- CAPTURE, `Dop`=1 while the pixel count is below WIDTH*HEIGHT (pixel accepted):
  - `WrAddr`/`WrData` are registered from the current count and `Gradient`, and `WrEn` is registered high.
  - The count increments.
  - `Column` increments. At WIDTH-1 it wraps to 0 and `Row` increments.
  - `EdgeCount` increments if `Gradient` ≠ 0.
- CAPTURE, `Dop`=1 when the count already equals WIDTH*HEIGHT: the pixel is dropped, no write occurs, and `Overrun` is set.
- CAPTURE, `Finish`=1: the next state is DONE. `Underrun` is set if the count, including any pixel accepted in the same cycle, is below WIDTH*HEIGHT.
- Simultaneous `Dop` and `Finish`: the pixel is processed first (accept or overrun rule), then the block moves to DONE.
- `Start` is ignored in CAPTURE.
- DONE: `Done`=1. `Row`, `Column`, `EdgeCount` and the flags hold. `Dop` and `Finish` are ignored. `Start`=1 goes to CAPTURE with the same clearing as from IDLE.
- `Row` and `Column` are zero-extended or truncated to 8 bits. The internal counter is ADDR_W+1 bits, so it never wraps.

## Timing
- Write latency: `Dop` sampled at edge N gives `WrEn`=1 with matching `WrAddr`/`WrData` in cycle N+1.
- `WrEn` is a one-cycle pulse per accepted pixel. Back-to-back `Dop` gives back-to-back writes.
- `WrAddr` and `WrData` hold their last values when `WrEn`=0.
- `Row`, `Column` and `EdgeCount` update at the same edge as the registered write.
- `Finish` sampled at edge N gives `Busy`=0 and `Done`=1 from cycle N+1. Flags are valid in the same cycle `Done` rises.
- `Start` sampled at edge N gives `Busy`=1 and cleared counters/flags from cycle N+1.
- `Reset` low mid-frame: at the next edge all outputs go to 0 and the state goes to IDLE. A pending write is dropped, so `WrEn` is 0 in the following cycle.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3, ADDR_W=4.
- Normal frame: `Start`, then 12 `Dop` pulses with `Gradient`=0,1,...,11, then `Finish`. Required: writes to addresses 0..11 with data 0..11, `EdgeCount`=11, `Row`=3, `Column`=0, `Done`=1, no flags.
- Gapped and simultaneous: the 12 pixels arrive with idle cycles between them, and the last `Dop` coincides with `Finish`. Required: all 12 writes occur, `Underrun`=0, `Done` rises 1 cycle after `Finish`.
- Short frame: 7 pixels, then `Finish`. Required: 7 writes (addresses 0..6), `Underrun`=1, `Row`=1, `Column`=3.
- Long frame: 14 pixels, then `Finish`. Required: exactly 12 writes, `Overrun`=1, `WrAddr` never exceeds 11.
- Reset and restart: assert `Reset`=0 after 5 pixels; all outputs are 0 the next cycle. Then `Start` and a full frame. Required: addresses restart at 0. A second `Start` from DONE clears `EdgeCount` and the flags.
